latch_mapper_gen: RTL and testbench
===================================

Name: latch_mapper_gen

Overview:
- Parametrised discrete-latch NES mapper core: one CPU-written latch register supplies the PRG and CHR bank numbers, optional mirroring control and an optional lock bit.
- Generalises the fixed 1-bit-PRG / 3-bit-CHR latch boards.
- Adds configurable field layout, write-address decode, bus-conflict emulation, read-modify-write double-write filtering, write lock and save-state access.
- Sits between the bus decode and the PRG/CHR memory address muxes, one instance per mapper number.

Parameters:
- PRG_BITS, 1: PRG 32K bank field width (1..4).
- PRG_SHIFT, 3: LSB position of the PRG field in the latch.
- CHR_BITS, 3: CHR 8K bank field width (1..5).
- CHR_SHIFT, 0: LSB position of the CHR field in the latch.
- MIR_BIT, -1: latch bit selecting mirroring (1 = vertical); -1 means use cfg_mir_v.
- LOCK_BIT, -1: latch bit that, once written as 1, blocks further writes; -1 means no lock.
- BUS_CONFLICT, 0: 1 means the effective write data is cpu_dat AND rom_dat.
- IGNORE_CONSEC, 0: 1 means a write in the cycle immediately following an accepted-or-attempted write is dropped.
- WR_MASK, 15'h0000: cpu_addr bits compared for write decode.
- WR_MATCH, 15'h0000: required value of the masked cpu_addr bits.
- MAP_IDX, 148: value returned at save-state address 127.

Ports:
- m2  in  1  CPU clock; all state updates on the falling edge.
- map_rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  15  CPU A14..A0.
- cpu_ce  in  1  low = $8000-$FFFF ROM region.
- cpu_rw  in  1  1 = read.
- cpu_dat  in  8  CPU write data.
- rom_dat  in  8  PRG ROM output data, for bus-conflict emulation.
- ppu_addr  in  14  PPU A13..A0.
- cfg_mir_v  in  1  static mirroring from sys_cfg.
- ss_act  in  1  save-state engine active.
- ss_we  in  1  save-state write strobe.
- ss_addr  in  8  save-state register index.
- ss_wdat  in  8  save-state write data.
- ss_rdat  out  8  save-state read data.
- prg_addr  out  PRG_BITS+15  PRG memory address.
- chr_addr  out  CHR_BITS+13  CHR memory address.
- ciram_a10  out  1  nametable select.
- locked  out  1  lock flag.

Behaviour:
- State registers:
  - latch[7:0]
  - lock (1 bit)
  - prev_wr (1 bit)
- All three registers are 0 on reset, asserted asynchronously. Outputs follow combinationally from the registers, so reset forces prg bank 0 and chr bank 0.
- wr_hit = !cpu_ce & !cpu_rw & ((cpu_addr & WR_MASK) == WR_MATCH).
- eff_dat = BUS_CONFLICT ? (cpu_dat & rom_dat) : cpu_dat.
- Normal mode (ss_act = 0), at each m2 falling edge:
  - prev_wr <= wr_hit.
  - A write is accepted iff all of:
    - wr_hit;
    - !(IGNORE_CONSEC & prev_wr);
    - !(LOCK_BIT >= 0 & lock).
  - On an accepted write: latch <= eff_dat. If LOCK_BIT >= 0, lock <= eff_dat[LOCK_BIT].
  - A dropped write leaves latch and lock unchanged but still sets prev_wr. A run of N back-to-back writes with IGNORE_CONSEC therefore accepts only the first.
- Save-state mode (ss_act = 1):
  - CPU writes are ignored and prev_wr <= 0.
  - If ss_we: address 0 gives latch <= ss_wdat; address 1 gives lock <= ss_wdat[0]. Other addresses are ignored.
  - Save-state writes bypass the lock.
- ss_rdat:
  - address 0: latch;
  - address 1: {7'b0, lock};
  - address 127: MAP_IDX[7:0];
  - any other address: 8'hFF.
- prg_addr:
  - [14:0] = cpu_addr[14:0];
  - upper PRG_BITS = latch[PRG_SHIFT +: PRG_BITS] when cpu_ce = 0, else 0;
  - bits [14:13] are forced to 0 when cpu_ce = 1.
- chr_addr = {latch[CHR_SHIFT +: CHR_BITS], ppu_addr[12:0]}.
- Mirroring:
  - mir_v = (MIR_BIT >= 0) ? latch[MIR_BIT] : cfg_mir_v.
  - ciram_a10 = mir_v ? ppu_addr[10] : ppu_addr[11].
- Fields that extend past bit 7 are a configuration error; the block must elaborate-time assert on them.
- Reset asserted mid-write: reset wins and no partial update is allowed.
- locked = lock.

Test Plan:
- Defaults: reset, then write $0B at $8000. Required: prg_addr[15] = 1 with cpu_ce = 0, chr_addr[15:13] = 3, ss_rdat@0 = $0B, ss_rdat@127 = $94.
- BUS_CONFLICT = 1: cpu_dat = $FF with rom_dat = $05. Required: latch = $05, chr bank 5, prg bank 0.
- IGNORE_CONSEC = 1: consecutive writes $01 then $02, then an idle cycle, then $03. Required: latch = $01 after the pair and $03 after the last write.
- LOCK_BIT = 7: write $81, then $02. Required: latch stays $81 and locked = 1. A save-state write of 0 to address 1, then a write of $02, gives latch = $02.
- WR_MASK = $4000, WR_MATCH = $4000: a write at $8000 is ignored; a write at $C000 is latched.
- MIR_BIT = 4: write $10, then $00. Required: ciram_a10 follows ppu_addr[10], then ppu_addr[11]. Reset asserted mid-run returns latch to 0 asynchronously.

Source files
------------

// File: rtl/latch_mapper_gen_if.sv
// latch_mapper_gen_if: CPU, PPU, save-state and memory-address signals of the latch mapper
interface latch_mapper_gen_if #(
  parameter int PRG_BITS = 1,
  parameter int CHR_BITS = 3
);
  logic [14:0] cpu_addr;
  logic cpu_ce;
  logic cpu_rw;
  logic [7:0] cpu_dat;
  logic [7:0] rom_dat;
  logic [13:0] ppu_addr;
  logic cfg_mir_v;
  logic ss_act;
  logic ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [PRG_BITS+14:0] prg_addr;
  logic [CHR_BITS+12:0] chr_addr;
  logic ciram_a10;
  logic locked;
  modport slave (
    input cpu_addr, cpu_ce, cpu_rw, cpu_dat, rom_dat, ppu_addr, cfg_mir_v,
    input ss_act, ss_we, ss_addr, ss_wdat,
    output ss_rdat, prg_addr, chr_addr, ciram_a10, locked
  );
  modport master (
    output cpu_addr, cpu_ce, cpu_rw, cpu_dat, rom_dat, ppu_addr, cfg_mir_v,
    output ss_act, ss_we, ss_addr, ss_wdat,
    input ss_rdat, prg_addr, chr_addr, ciram_a10, locked
  );
endinterface

// File: rtl/latch_mapper_gen.sv
// latch_mapper_gen: parametrised discrete-latch NES mapper (PRG/CHR bank latch, mirroring, lock, save-state)
module latch_mapper_gen #(
  parameter int PRG_BITS = 1,
  parameter int PRG_SHIFT = 3,
  parameter int CHR_BITS = 3,
  parameter int CHR_SHIFT = 0,
  parameter int MIR_BIT = -1,
  parameter int LOCK_BIT = -1,
  parameter int BUS_CONFLICT = 0,
  parameter int IGNORE_CONSEC = 0,
  parameter logic [14:0] WR_MASK = 15'h0000,
  parameter logic [14:0] WR_MATCH = 15'h0000,
  parameter int MAP_IDX = 148
) (
  input logic m2,
  input logic map_rst_n,
  latch_mapper_gen_if.slave bus
);
  localparam bit HAS_LOCK = LOCK_BIT >= 0;
  localparam bit HAS_MIR = MIR_BIT >= 0;
  localparam int LB = HAS_LOCK ? LOCK_BIT : 0;
  localparam int MB = HAS_MIR ? MIR_BIT : 0;
  localparam logic [7:0] IDX = 8'(MAP_IDX);
  if (PRG_BITS < 1 || PRG_BITS > 4 || CHR_BITS < 1 || CHR_BITS > 5 ||
      PRG_SHIFT < 0 || CHR_SHIFT < 0 || PRG_SHIFT + PRG_BITS > 8 ||
      CHR_SHIFT + CHR_BITS > 8 || MIR_BIT > 7 || LOCK_BIT > 7) begin : g_cfg_err
    $error("latch_mapper_gen: latch field outside bits 7..0");
  end
  logic [7:0] latch_q;
  logic lock_q;
  logic prev_wr_q;
  logic wr_hit;
  logic accept;
  logic mir_v;
  logic [7:0] eff_dat;
  logic unused_bits;
  assign wr_hit = !bus.cpu_ce & !bus.cpu_rw & ((bus.cpu_addr & WR_MASK) == WR_MATCH);
  assign eff_dat = BUS_CONFLICT != 0 ? bus.cpu_dat & bus.rom_dat : bus.cpu_dat;
  // a write right after any CPU write attempt is dropped to mimic RMW double writes
  assign accept = wr_hit & !(IGNORE_CONSEC != 0 && prev_wr_q) & !(HAS_LOCK && lock_q);
  always_ff @(negedge m2 or negedge map_rst_n)
    if (!map_rst_n) begin
      latch_q <= '0;
      lock_q <= 1'b0;
      prev_wr_q <= 1'b0;
    end else if (bus.ss_act) begin
      prev_wr_q <= 1'b0;
      if (bus.ss_we && bus.ss_addr == 8'd0) latch_q <= bus.ss_wdat;
      if (bus.ss_we && bus.ss_addr == 8'd1) lock_q <= bus.ss_wdat[0];
    end else begin
      prev_wr_q <= wr_hit;
      if (accept) begin
        latch_q <= eff_dat;
        if (HAS_LOCK) lock_q <= eff_dat[LB];
      end
    end
  always_comb
    bus.ss_rdat = bus.ss_addr == 8'd0 ? latch_q :
                  bus.ss_addr == 8'd1 ? {7'b0, lock_q} :
                  bus.ss_addr == 8'd127 ? IDX : 8'hFF;
  assign bus.prg_addr = {latch_q[PRG_SHIFT +: PRG_BITS] & {PRG_BITS{!bus.cpu_ce}},
                         bus.cpu_addr[14:13] & {2{!bus.cpu_ce}}, bus.cpu_addr[12:0]};
  assign bus.chr_addr = {latch_q[CHR_SHIFT +: CHR_BITS], bus.ppu_addr[12:0]};
  assign mir_v = HAS_MIR ? latch_q[MB] : bus.cfg_mir_v;
  assign bus.ciram_a10 = mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11];
  assign bus.locked = lock_q;
  assign unused_bits = ^{bus.ppu_addr[13], bus.rom_dat, bus.ss_wdat[7:1]};
endmodule

// File: tb/tb_latch_mapper_gen.sv
// tb_latch_mapper_gen: two mapper configurations driven in parallel, checked against a rule-level model
module tb_latch_mapper_gen;
  logic m2 = 1'b1;
  logic rst_n = 1'b0;
  logic run_cmp = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [14:0] cpu_addr;
  logic cpu_ce, cpu_rw, cfg_mir_v, ss_act, ss_we;
  logic [7:0] cpu_dat, rom_dat, ss_addr, ss_wdat;
  logic [13:0] ppu_addr;
  always #5 m2 = ~m2;
  latch_mapper_gen_if #(.PRG_BITS(1), .CHR_BITS(3)) ia ();
  latch_mapper_gen_if #(.PRG_BITS(2), .CHR_BITS(3)) ib ();
  assign ia.cpu_addr = cpu_addr;
  assign ia.cpu_ce = cpu_ce;
  assign ia.cpu_rw = cpu_rw;
  assign ia.cpu_dat = cpu_dat;
  assign ia.rom_dat = rom_dat;
  assign ia.ppu_addr = ppu_addr;
  assign ia.cfg_mir_v = cfg_mir_v;
  assign ia.ss_act = ss_act;
  assign ia.ss_we = ss_we;
  assign ia.ss_addr = ss_addr;
  assign ia.ss_wdat = ss_wdat;
  assign ib.cpu_addr = cpu_addr;
  assign ib.cpu_ce = cpu_ce;
  assign ib.cpu_rw = cpu_rw;
  assign ib.cpu_dat = cpu_dat;
  assign ib.rom_dat = rom_dat;
  assign ib.ppu_addr = ppu_addr;
  assign ib.cfg_mir_v = cfg_mir_v;
  assign ib.ss_act = ss_act;
  assign ib.ss_we = ss_we;
  assign ib.ss_addr = ss_addr;
  assign ib.ss_wdat = ss_wdat;
  latch_mapper_gen u_a (.m2(m2), .map_rst_n(rst_n), .bus(ia.slave));
  latch_mapper_gen #(
    .PRG_BITS(2), .PRG_SHIFT(5), .CHR_BITS(3), .CHR_SHIFT(0), .MIR_BIT(4), .LOCK_BIT(7),
    .BUS_CONFLICT(1), .IGNORE_CONSEC(1), .WR_MASK(15'h4000), .WR_MATCH(15'h4000), .MAP_IDX(3)
  ) u_b (.m2(m2), .map_rst_n(rst_n), .bus(ib.slave));
  int pb[2] = '{1, 2};
  int ps[2] = '{3, 5};
  int cb[2] = '{3, 3};
  int cs[2] = '{0, 0};
  int mir[2] = '{-1, 4};
  int lk[2] = '{-1, 7};
  int bc[2] = '{0, 1};
  int ic[2] = '{0, 1};
  int msk[2] = '{0, 'h4000};
  int mtc[2] = '{0, 'h4000};
  int idx[2] = '{148, 3};
  int m_latch[2] = '{0, 0};
  int m_lock[2] = '{0, 0};
  int m_prev[2] = '{0, 0};
  always @(negedge m2 or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_latch[k] = 0;
        m_lock[k] = 0;
        m_prev[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int hit, d;
        if (ss_act) begin
          m_prev[k] = 0;
          if (ss_we && ss_addr == 0) m_latch[k] = ss_wdat;
          if (ss_we && ss_addr == 1) m_lock[k] = ss_wdat % 2;
        end else begin
          hit = (!cpu_ce && !cpu_rw && ((int'(cpu_addr) & msk[k]) == mtc[k])) ? 1 : 0;
          d = bc[k] != 0 ? int'(cpu_dat & rom_dat) : int'(cpu_dat);
          if (hit == 1 && !(ic[k] != 0 && m_prev[k] == 1) && !(lk[k] >= 0 && m_lock[k] == 1)) begin
            m_latch[k] = d;
            if (lk[k] >= 0) m_lock[k] = (d >> lk[k]) % 2;
          end
          m_prev[k] = hit;
        end
      end
    end
  function automatic logic [19:0] e_prg(int k);
    int bank = cpu_ce ? 0 : (m_latch[k] >> ps[k]) % (1 << pb[k]);
    int low = cpu_ce ? int'(cpu_addr) % 'h2000 : int'(cpu_addr);
    return 20'(bank * 'h8000 + low);
  endfunction
  function automatic logic [19:0] e_chr(int k);
    return 20'(((m_latch[k] >> cs[k]) % (1 << cb[k])) * 'h2000 + int'(ppu_addr) % 'h2000);
  endfunction
  function automatic logic [19:0] e_cir(int k);
    int mv = mir[k] >= 0 ? (m_latch[k] >> mir[k]) % 2 : int'(cfg_mir_v);
    return 20'(mv != 0 ? (ppu_addr / 'h400) % 2 : (ppu_addr / 'h800) % 2);
  endfunction
  function automatic logic [19:0] e_ss(int k);
    return ss_addr == 0 ? 20'(m_latch[k]) : ss_addr == 1 ? 20'(m_lock[k]) :
           ss_addr == 127 ? 20'(idx[k] % 256) : 20'hFF;
  endfunction
  task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask
  always @(posedge m2) begin
    #3;
    if (run_cmp) begin
      chk("A.prg", 20'(ia.prg_addr), e_prg(0));
      chk("A.chr", 20'(ia.chr_addr), e_chr(0));
      chk("A.cir", 20'(ia.ciram_a10), e_cir(0));
      chk("A.ss", 20'(ia.ss_rdat), e_ss(0));
      chk("A.lock", 20'(ia.locked), 20'(m_lock[0]));
      chk("B.prg", 20'(ib.prg_addr), e_prg(1));
      chk("B.chr", 20'(ib.chr_addr), e_chr(1));
      chk("B.cir", 20'(ib.ciram_a10), e_cir(1));
      chk("B.ss", 20'(ib.ss_rdat), e_ss(1));
      chk("B.lock", 20'(ib.locked), 20'(m_lock[1]));
    end
  end
  task automatic step(input logic ce, input logic rw, input logic [14:0] a, input logic [7:0] d, input logic [7:0] r);
    cpu_ce = ce;
    cpu_rw = rw;
    cpu_addr = a;
    cpu_dat = d;
    rom_dat = r;
    ss_act = 1'b0;
    ss_we = 1'b0;
    @(posedge m2);
    #1;
  endtask
  task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic [7:0] r);
    step(1'b0, 1'b0, a, d, r);
  endtask
  task automatic probe(input logic ce, input logic [14:0] a, input logic [13:0] p, input logic [7:0] sa);
    ppu_addr = p;
    ss_addr = sa;
    step(ce, 1'b1, a, 8'h00, 8'hFF);
  endtask
  initial begin
    cpu_addr = '0;
    cpu_ce = 1'b1;
    cpu_rw = 1'b1;
    cpu_dat = '0;
    rom_dat = 8'hFF;
    ppu_addr = '0;
    cfg_mir_v = 1'b0;
    ss_act = 1'b0;
    ss_we = 1'b0;
    ss_addr = '0;
    ss_wdat = '0;
    repeat (3) @(posedge m2);
    #1;
    rst_n = 1'b1;
    run_cmp = 1'b1;
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("rst A.latch", 20'(ia.ss_rdat), 20'h00);
    chk("rst B.prg", 20'(ib.prg_addr), 20'h00000);
    chk("rst A.chr", 20'(ia.chr_addr), 20'h00000);
    probe(1'b0, 15'h0000, 14'h0000, 8'd127);
    chk("A.idx", 20'(ia.ss_rdat), 20'h94);
    chk("B.idx", 20'(ib.ss_rdat), 20'h03);
    wr(15'h0000, 8'h0B, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("def A.prg", 20'(ia.prg_addr), 20'h08000);
    chk("def A.chr", 20'(ia.chr_addr), 20'h06000);
    chk("def A.latch", 20'(ia.ss_rdat), 20'h0B);
    chk("mask B.8000", 20'(ib.ss_rdat), 20'h00);
    wr(15'h4000, 8'hFF, 8'h05);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("bc B.latch", 20'(ib.ss_rdat), 20'h05);
    chk("bc B.chr", 20'(ib.chr_addr), 20'h0A000);
    chk("bc B.prg", 20'(ib.prg_addr), 20'h00000);
    chk("nobc A.latch", 20'(ia.ss_rdat), 20'hFF);
    wr(15'h4000, 8'h01, 8'hFF);
    wr(15'h4000, 8'h02, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("consec B.pair", 20'(ib.ss_rdat), 20'h01);
    chk("consec A.pair", 20'(ia.ss_rdat), 20'h02);
    wr(15'h4000, 8'h03, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("consec B.last", 20'(ib.ss_rdat), 20'h03);
    wr(15'h4000, 8'h81, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    wr(15'h4000, 8'h02, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("lock B.latch", 20'(ib.ss_rdat), 20'h81);
    chk("lock B.locked", 20'(ib.locked), 20'h1);
    ss_addr = 8'd1;
    ss_wdat = 8'h00;
    ss_we = 1'b1;
    ss_act = 1'b1;
    @(posedge m2);
    #1;
    wr(15'h4000, 8'h02, 8'hFF);
    probe(1'b0, 15'h0000, 14'h0000, 8'd0);
    chk("unlock B.latch", 20'(ib.ss_rdat), 20'h02);
    chk("unlock B.locked", 20'(ib.locked), 20'h0);
    wr(15'h4000, 8'h10, 8'hFF);
    probe(1'b1, 15'h0000, 14'h0400, 8'd0);
    chk("mirv B.a10", 20'(ib.ciram_a10), 20'h1);
    chk("cfgh A.a10", 20'(ia.ciram_a10), 20'h0);
    probe(1'b1, 15'h0000, 14'h0800, 8'd0);
    chk("mirv B.a11", 20'(ib.ciram_a10), 20'h0);
    wr(15'h4000, 8'h00, 8'hFF);
    probe(1'b1, 15'h0000, 14'h0800, 8'd0);
    chk("mirh B.a11", 20'(ib.ciram_a10), 20'h1);
    probe(1'b1, 15'h0000, 14'h0400, 8'd0);
    chk("mirh B.a10", 20'(ib.ciram_a10), 20'h0);
    wr(15'h4000, 8'h0B, 8'hFF);
    chk("pre-rst B.latch", 20'(ib.ss_rdat), 20'h0B);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst A.latch", 20'(ia.ss_rdat), 20'h00);
    chk("arst B.latch", 20'(ib.ss_rdat), 20'h00);
    @(posedge m2);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst_n = $urandom_range(0, 199) != 0;
      cpu_addr = 15'($urandom);
      cpu_ce = $urandom_range(0, 3) == 0;
      cpu_rw = $urandom_range(0, 1) == 1;
      cpu_dat = 8'($urandom);
      rom_dat = $urandom_range(0, 1) == 1 ? 8'hFF : 8'($urandom);
      ppu_addr = 14'($urandom);
      cfg_mir_v = $urandom_range(0, 1) == 1;
      ss_act = $urandom_range(0, 15) == 0;
      ss_we = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: ss_addr = 8'd0;
        1: ss_addr = 8'd1;
        2: ss_addr = 8'd127;
        default: ss_addr = 8'($urandom);
      endcase
      ss_wdat = 8'($urandom);
      @(posedge m2);
      #1;
    end
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
